// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared states and stream-format constants for the boot loader
package imem_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERROR,
    ST_CSUM
  } loader_state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs little-endian bytes into 32-bit words
module loader_word_assembler
  import imem_program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt_q;
  logic [23:0] shreg_q;

  // The final byte is combined directly so the word is ready on its handshake cycle.
  assign word      = {byte_data, shreg_q};
  assign word_done = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (byte_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shreg_q <= {byte_data, shreg_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - boot-time byte-stream loader into instruction memory
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 128,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

  loader_state_t     state_q, next_state, fin_state;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q, len_next, word_idx_q, words_loaded_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, asm_word;
  logic              hs, data_hs, word_done, last_word;

  assign hs        = s_valid && s_ready;
  assign data_hs   = hs && (state_q == ST_DATA) && !restart;
  assign len_next  = {s_data, len_lo_q};
  assign last_word = (word_idx_q + 16'd1) >= len_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  assign fin_state = ST_CSUM;
`else
  assign fin_state = ST_RUN;
`endif

  loader_word_assembler u_asm (
    .clk        (clk),
    .arst_n     (arst_n),
    .clear      (restart),
    .byte_valid (data_hs),
    .byte_data  (s_data),
    .word       (asm_word),
    .word_done  (word_done)
  );

  always_comb begin
    next_state = state_q;
    s_ready    = 1'b0;
    case (state_q)
      ST_IDLE:   next_state = ST_LEN_LO;
      ST_LEN_LO: begin
        s_ready = 1'b1;
        if (hs) next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        s_ready = 1'b1;
        if (hs) begin
          if (len_next == 16'd0)                  next_state = fin_state;
          else if ({16'd0, len_next} > MAX_WORDS) next_state = ST_ERROR;
          else                                    next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (word_done) next_state = ST_WRITE;
      end
      ST_WRITE:  next_state = last_word ? fin_state : ST_DATA;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        s_ready = 1'b1;
        if (hs) next_state = (s_data == csum_q) ? ST_RUN : ST_ERROR;
      end
`endif
      default:   next_state = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= ST_IDLE;
      len_lo_q       <= '0;
      len_q          <= '0;
      word_idx_q     <= '0;
      words_loaded_q <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else if (restart) begin
      // Any byte handshaking in this cycle is discarded.
      state_q        <= ST_IDLE;
      len_lo_q       <= '0;
      len_q          <= '0;
      word_idx_q     <= '0;
      words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q <= next_state;
      if (state_q == ST_LEN_LO && hs) len_lo_q <= s_data;
      if (state_q == ST_LEN_HI && hs) len_q <= len_next;
      if (word_done) begin
        wdata_q <= asm_word;
        addr_q  <= ADDR_W'({word_idx_q, 2'b00});
      end
      if (state_q == ST_WRITE) begin
        word_idx_q     <= word_idx_q + 16'd1;
        words_loaded_q <= words_loaded_q + 16'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (data_hs) csum_q <= csum_q ^ s_data;
`endif
    end
  end

  assign addr_ext     = addr_q;
  assign wdata_ext    = wdata_q;
  assign wen_ext      = (state_q == ST_WRITE);
  assign ren_ext      = 1'b0;
  assign cpu_enable   = (state_q == ST_RUN);
  assign error        = (state_q == ST_ERROR);
  assign words_loaded = words_loaded_q;
  // No byte has been taken while in LEN_LO, so it does not count as busy.
  assign busy = (state_q == ST_LEN_HI) || (state_q == ST_DATA) ||
                (state_q == ST_WRITE)  || (state_q == ST_CSUM);

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - randomized self-checking bench for imem_program_loader
// Exercises the LOADER_CHECKSUM_EN trailer when that macro is defined.
module tb_imem_program_loader;

  localparam int MAXW = 128;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        restart;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  imem_program_loader dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .restart      (restart),
    .addr_ext     (addr_ext),
    .wen_ext      (wen_ext),
    .ren_ext      (ren_ext),
    .wdata_ext    (wdata_ext),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] words[$];
  logic [63:0] got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      got_addr.push_back(addr_ext);
      got_data.push_back(wdata_ext);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_gap(input int gap_max);
    return (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
  endfunction

  // Called and returns on a negedge; back-to-back calls with gap 0 present bytes without bubbles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    repeat (gap) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    cnt = 0;
    while (s_ready !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      chk("hs_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    restart = 1'b0;
    s_data  = 8'h00;
    #2 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(wen_ext), 64'd0);
    chk("rst_ren", 64'(ren_ext), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_addr", addr_ext, 64'd0);
    chk("rst_wdata", 64'(wdata_ext), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    arst_n = 1'b1;
    chk("idle_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("lenlo_s_ready", 64'(s_ready), 64'd1);
    chk("lenlo_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_error", 64'(error), 64'd0);
    chk("rs_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rs_words", 64'(words_loaded), 64'd0);
    chk("rs_s_ready", 64'(s_ready), 64'd0);
  endtask

  // Sends a complete stream for the first n entries of words; checks output timing around the end.
  task automatic load(input int n, input int gap_max);
    logic [7:0]  x;
    logic [15:0] nn;
    logic [31:0] w;
    x  = 8'h00;
    nn = 16'(n);
    got_addr.delete();
    got_data.delete();
    send_byte(nn[7:0], pick_gap(gap_max));
    send_byte(nn[15:8], pick_gap(gap_max));
    if (n > MAXW) return;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], pick_gap(gap_max));
        x = x ^ w[8*b +: 8];
        if (i == 0 && b == 0) chk("data_busy", 64'(busy), 64'd1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, pick_gap(gap_max));
    chk("csum_run", 64'(cpu_enable), 64'd1);
`else
    if (n == 0) begin
      chk("n0_run_t1", 64'(cpu_enable), 64'd1);
    end else begin
      chk("last_wen_t1", 64'(wen_ext), 64'd1);
      chk("last_addr_t1", addr_ext, 64'(4 * (n - 1)));
      chk("last_cpu_t1", 64'(cpu_enable), 64'd0);
      @(negedge clk);
      chk("last_cpu_t2", 64'(cpu_enable), 64'd1);
      chk("last_wen_t2", 64'(wen_ext), 64'd0);
    end
`endif
  endtask

  task automatic check_run(input int n);
    int nw;
    repeat (3) @(negedge clk);
    chk("run_cpu_enable", 64'(cpu_enable), 64'd1);
    chk("run_error", 64'(error), 64'd0);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_s_ready", 64'(s_ready), 64'd0);
    chk("run_words", 64'(words_loaded), 64'(n));
    chk("run_nwrites", 64'(got_addr.size()), 64'(n));
    nw = (got_addr.size() < n) ? got_addr.size() : n;
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("wr_addr[%0d]", i), got_addr[i], 64'(4 * i));
      chk($sformatf("wr_data[%0d]", i), 64'(got_data[i]), 64'(words[i]));
    end
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int n;
    arst_n  = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    restart = 1'b0;
    do_reset();

    words.delete();
    words.push_back(32'h00100513);
    words.push_back(32'h00200593);
    load(2, 0);
    check_run(2);

    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (5) @(negedge clk);
    s_valid = 1'b0;
    chk("stray_words", 64'(words_loaded), 64'd2);
    chk("stray_writes", 64'(got_addr.size()), 64'd2);
    chk("stray_cpu", 64'(cpu_enable), 64'd1);

    do_restart();
    load(0, 0);
    check_run(0);

    do_restart();
    load(MAXW + 1, 0);
    chk("err_error", 64'(error), 64'd1);
    chk("err_s_ready", 64'(s_ready), 64'd0);
    chk("err_cpu", 64'(cpu_enable), 64'd0);
    repeat (2) @(negedge clk);
    chk("err_sticky", 64'(error), 64'd1);
    chk("err_nwrites", 64'(got_addr.size()), 64'd0);
    do_restart();

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(8, 1));
      rand_words(n);
      load(n, 3);
      check_run(n);
      do_restart();
      load(n, 0);
      check_run(n);
      do_restart();
    end

    rand_words(MAXW);
    load(MAXW, 1);
    check_run(MAXW);
    do_restart();

    rand_words(1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h5A, 0);
    s_valid = 1'b1;
    s_data  = 8'hC3;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    s_valid = 1'b0;
    chk("rsb_words", 64'(words_loaded), 64'd0);
    chk("rsb_busy", 64'(busy), 64'd0);
    load(1, 2);
    check_run(1);
    do_restart();

    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEE, 0);
    send_byte(8'hDD, 0);
    do_reset();
    words.delete();
    words.push_back(32'h00100513);
    load(1, 0);
    check_run(1);

`ifdef LOADER_CHECKSUM_EN
    do_restart();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    chk("bad_csum_error", 64'(error), 64'd1);
    chk("bad_csum_cpu", 64'(cpu_enable), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
